idiv_fu: RTL and testbench

Sequential integer divide/remainder functional unit for the RV32M DIV, DIVU, REM and REMU instructions. It sits beside the integer multiply unit in the EXE stage. It accepts one operation per request handshake and runs a 32-iteration radix-2 restoring divide. It returns a sign-corrected 32-bit result through a held valid/ack handshake, and EXE stalls until that result is taken.

---
 rtl/cpu_params_pkg.sv | 8 +
 rtl/cpu_structs_pkg.sv | 51 +++++
 rtl/idiv_step.sv | 22 ++
 rtl/idiv_fu.sv | 147 ++++++++++++++
 tb/tb_idiv_fu.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// Shared CPU sizing parameters.
package cpu_params_pkg;

    localparam int unsigned RSZ        = 32;
    localparam int unsigned IDIV_ITER  = RSZ;
    localparam int unsigned IDIV_CNT_W = $clog2(IDIV_ITER);

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared CPU enums, payload structs and divider classification helpers.
package cpu_structs_pkg;

    import cpu_params_pkg::*;

    // Encoding matches funct3[1:0] of the RV32M divide group.
    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } ID_OP_TYPE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } IDIV_STATE_TYPE;

    typedef struct packed {
        ID_OP_TYPE          op;
        logic [RSZ-1:0]     rs1;
        logic [RSZ-1:0]     rs2;
    } idiv_req_t;

    localparam logic [RSZ-1:0] INT_MIN = {1'b1, {(RSZ-1){1'b0}}};

    function automatic logic op_is_signed(input ID_OP_TYPE op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input ID_OP_TYPE op);
        return (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_div0(input logic [RSZ-1:0] rs2);
        return rs2 == '0;
    endfunction

    function automatic logic is_ovf(input ID_OP_TYPE op, input logic [RSZ-1:0] rs1,
                                    input logic [RSZ-1:0] rs2);
        return op_is_signed(op) && (rs1 == INT_MIN) && (rs2 == '1);
    endfunction

    // Magnitude; INT_MIN maps to itself and is read as unsigned.
    function automatic logic [RSZ-1:0] abs_val(input logic [RSZ-1:0] v);
        return v[RSZ-1] ? (RSZ'(0) - v) : v;
    endfunction

endpackage

// File: rtl/idiv_step.sv
// One combinational radix-2 restoring divide step.
module idiv_step
    import cpu_params_pkg::*;
(
    input  logic [RSZ:0]   rem_in,
    input  logic           dvd_msb_in,
    input  logic [RSZ-1:0] dvs_in,
    output logic [RSZ:0]   rem_out,
    output logic           q_out
);

    logic [RSZ+1:0] shifted;
    logic [RSZ:0]   diff;

    always_comb begin
        shifted = {rem_in, dvd_msb_in};
        q_out   = shifted >= {2'b00, dvs_in};
        diff    = shifted[RSZ:0] - {1'b0, dvs_in};
        rem_out = q_out ? diff : shifted[RSZ:0];
    end

endmodule

// File: rtl/idiv_fu.sv
// RV32M DIV/DIVU/REM/REMU functional unit: 32-step restoring divider with
// sign fix-up and a held valid/ack result handshake.
module idiv_fu
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic           clk_in,
    input  logic           reset_n_in,
    input  logic           flush_in,
    input  logic           start_in,
    output logic           ready_out,
    input  logic [1:0]     op_in,
    input  logic [RSZ-1:0] Rs1_data_in,
    input  logic [RSZ-1:0] Rs2_data_in,
    output logic           rslt_valid_out,
    input  logic           rslt_ack_in,
    output logic [RSZ-1:0] Rd_data_out
);

    IDIV_STATE_TYPE        state_q, state_d;
    logic [IDIV_CNT_W-1:0] cnt_q, cnt_d;
    idiv_req_t             req_q, req_d;
    logic [RSZ:0]          rem_q, rem_d;
    logic [RSZ-1:0]        quo_q, quo_d;
    logic [RSZ-1:0]        dvs_q, dvs_d;
    logic [RSZ-1:0]        rd_q, rd_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;

    logic [RSZ:0]          step_rem;
    logic                  step_q;
    ID_OP_TYPE             op_in_e;
    logic [RSZ-1:0]        fix_rslt;

    assign op_in_e = ID_OP_TYPE'(op_in);

    // Dividend shifts out of the quotient register MSB-first while quotient bits enter at the LSB.
    idiv_step u_step (
        .rem_in     (rem_q),
        .dvd_msb_in (quo_q[RSZ-1]),
        .dvs_in     (dvs_q),
        .rem_out    (step_rem),
        .q_out      (step_q)
    );

    // Special cases override the core; otherwise apply RV32M sign rules.
    always_comb begin
        fix_rslt = quo_q;
        if (is_div0(req_q.rs2)) begin
            fix_rslt = op_is_rem(req_q.op) ? req_q.rs1 : '1;
        end else if (is_ovf(req_q.op, req_q.rs1, req_q.rs2)) begin
            fix_rslt = op_is_rem(req_q.op) ? '0 : INT_MIN;
        end else if (op_is_rem(req_q.op)) begin
            fix_rslt = (op_is_signed(req_q.op) && req_q.rs1[RSZ-1])
                     ? (RSZ'(0) - rem_q[RSZ-1:0]) : rem_q[RSZ-1:0];
        end else begin
            fix_rslt = (op_is_signed(req_q.op) && (req_q.rs1[RSZ-1] ^ req_q.rs2[RSZ-1]))
                     ? (RSZ'(0) - quo_q) : quo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rd_d    = rd_q;

        if (flush_in) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_in) begin
                        req_d.op  = op_in_e;
                        req_d.rs1 = Rs1_data_in;
                        req_d.rs2 = Rs2_data_in;
                        rem_d     = '0;
                        cnt_d     = '0;
                        quo_d     = op_is_signed(op_in_e) ? abs_val(Rs1_data_in) : Rs1_data_in;
                        dvs_d     = op_is_signed(op_in_e) ? abs_val(Rs2_data_in) : Rs2_data_in;
                        if (FAST_SPECIAL && (is_div0(Rs2_data_in) ||
                                             is_ovf(op_in_e, Rs1_data_in, Rs2_data_in))) begin
                            state_d = FIX;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d = step_rem;
                    quo_d = {quo_q[RSZ-2:0], step_q};
                    cnt_d = cnt_q + IDIV_CNT_W'(1);
                    if (cnt_q == IDIV_CNT_W'(IDIV_ITER - 1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    rd_d    = fix_rslt;
                    state_d = DONE;
                end
                DONE: begin
                    if (rslt_ack_in) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_out      = ready_q;
    assign rslt_valid_out = valid_q;
    assign Rd_data_out    = rd_q;

endmodule

// File: tb/tb_idiv_fu.sv
// Directed bench for idiv_fu: a FAST_SPECIAL=1 unit and a FAST_SPECIAL=0 unit.
module tb_idiv_fu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        start, start_s;
    logic        ack, ack_s;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        ready, valid, ready_s, valid_s;
    logic [31:0] rd, rd_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idiv_fu #(.FAST_SPECIAL(1'b1)) u_fast (
        .clk_in         (clk),
        .reset_n_in     (rst_n),
        .flush_in       (flush),
        .start_in       (start),
        .ready_out      (ready),
        .op_in          (op),
        .Rs1_data_in    (a),
        .Rs2_data_in    (b),
        .rslt_valid_out (valid),
        .rslt_ack_in    (ack),
        .Rd_data_out    (rd)
    );

    idiv_fu #(.FAST_SPECIAL(1'b0)) u_slow (
        .clk_in         (clk),
        .reset_n_in     (rst_n),
        .flush_in       (flush),
        .start_in       (start_s),
        .ready_out      (ready_s),
        .op_in          (op),
        .Rs1_data_in    (a),
        .Rs2_data_in    (b),
        .rslt_valid_out (valid_s),
        .rslt_ack_in    (ack_s),
        .Rd_data_out    (rd_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, check latency, data and handshake.
    task automatic run_op(input string tag, input bit slow, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat);
        int   cyc;
        logic v;
        @(negedge clk);
        op = o; a = x; b = y;
        if (slow) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_s = 1'b0;
        op = 2'd0; a = 32'hDEAD_BEEF; b = 32'h0;
        cyc = 0;
        v = slow ? valid_s : valid;
        while (!v && cyc < 100) begin
            @(negedge clk);
            cyc++;
            v = slow ? valid_s : valid;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_rd"}, slow ? rd_s : rd, exp);
        chk({tag, "_busy"}, 32'(slow ? ready_s : ready), 32'd0);
        if (slow) ack_s = 1'b1; else ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; ack_s = 1'b0;
        chk({tag, "_rdy_after_ack"}, 32'(slow ? ready_s : ready), 32'd1);
        chk({tag, "_vld_after_ack"}, 32'(slow ? valid_s : valid), 32'd0);
    endtask

    initial begin
        logic [31:0] hold;
        bit          ok;
        int          cyc;

        rst_n = 1'b0; flush = 1'b0; start = 1'b0; start_s = 1'b0;
        ack = 1'b0; ack_s = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rd", rd, 32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7",  1'b0, 2'd1, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7",  1'b0, 2'd3, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2",    1'b0, 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",    1'b0, 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2",    1'b0, 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",    1'b0, 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_5_0",     1'b0, 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0",    1'b0, 2'd3, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_m5_0",    1'b0, 2'd0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_m5_0",    1'b0, 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_op("div_ovf",     1'b0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     1'b0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_max_1",  1'b0, 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
        run_op("s_div_5_0",   1'b1, 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("s_remu_5_0",  1'b1, 2'd3, 32'd5, 32'd0, 32'd5, 33);
        run_op("s_div_m5_0",  1'b1, 2'd0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("s_div_ovf",   1'b1, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

        // Backpressure: hold the result for 10 cycles while start pulses arrive.
        @(negedge clk);
        op = 2'd1; a = 32'd1000; b = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_lat", 32'(cyc), 32'd33);
        hold = rd;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            a = 32'd77; b = 32'd7;
            @(negedge clk);
            if (rd !== hold || valid !== 1'b1 || ready !== 1'b0) ok = 1'b0;
        end
        start = 1'b0;
        chk("bp_rd", rd, 32'd100);
        chk("bp_stable", 32'(ok), 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("bp_rdy_after_ack", 32'(ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("bp_no_queued_op", 32'(valid), 32'd0);

        // Flush at CALC step 10.
        op = 2'd1; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'd1);
        chk("flush_valid", 32'(valid), 32'd0);
        chk("flush_rd_kept", rd, 32'd100);
        // Start coincident with flush is dropped.
        op = 2'd1; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ready", 32'(ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("flush_no_result", 32'(valid), 32'd0);
        run_op("divu_9_3",    1'b0, 2'd1, 32'd9, 32'd3, 32'd3, 33);

        // Asynchronous reset mid-CALC.
        op = 2'd0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_rd", rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_still_idle", 32'(valid), 32'd0);
        run_op("post_rst_div", 1'b0, 2'd0, 32'd100, 32'd7, 32'd14, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
